ring_heater_lock_ctrl: RTL and testbench
========================================

# ring_heater_lock_ctrl

Closed-loop thermal tuning controller for one resonant ring: drives the ring's heater net with a pulse-density-modulated (PDM) bit stream and finds the resonance with a full heater-code sweep. After the sweep it tracks the resonance with a ±1-code dither loop, using drop-port photodetector power samples. It is the synthesizable counterpart of the behavioural thermal tuner and sits between a drop-port power ADC and a ResonantRing heater input.

## Interface
- BIT_WIDTH, 8, heater code width; PDM duty = code / 2^BIT_WIDTH
- PWR_WIDTH, 12, unsigned power sample width
- SETTLE_CYCLES, 1000, cycles waited after every code change before a sample is accepted (≥1)
- DEADBAND, 4, minimum probe power difference that moves the tracking centre
- LOSS_THRESH, 16, in TRACK, both probes below this → FAULT
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  0 forces IDLE from any state
- start  input  1  single-cycle pulse; begins sweep from IDLE or FAULT (ignored elsewhere)
- pwr_valid  input  1  pwr_data qualifier
- pwr_data  input  PWR_WIDTH  drop-port power sample
- heater  output  1  PDM heater drive
- code  output  BIT_WIDTH  current applied heater code
- state  output  2  IDLE=0, SWEEP=1, TRACK=2, FAULT=3
- locked  output  1  high while state==TRACK
- done  output  1  one-cycle pulse on SWEEP→TRACK
- lost_lock  output  1  high while state==FAULT

## Operation
- Reset: state=IDLE, code=0, PDM accumulator=0, heater=0, settle counter=0, best_pwr=0, best_code=0, done/locked/lost_lock=0.
- PDM: first-order accumulator acc (BIT_WIDTH bits). Each cycle {carry,acc} ← acc + code; heater ← carry (registered). code=0 → heater never high; max code → high 2^BW−1 of every 2^BW cycles.
- Settle counter: cleared to 0 on the edge where code changes; increments each cycle and saturates at SETTLE_CYCLES. A sample is accepted only on a cycle with pwr_valid=1 and counter==SETTLE_CYCLES. Other samples are dropped.
- IDLE: code=0. On start&enable → SWEEP with code=0, best_pwr=0, best_code=0, counter=0.
- SWEEP: on each accepted sample, if pwr_data > best_pwr (strict), then best_pwr←pwr_data and best_code←code. Ties keep the lower code. If code==2^BW−1 → TRACK with centre=best_code, pulse done. Otherwise code←code+1.
- TRACK: probe cycle of two phases.
  - Phase HI: code=min(centre+1, max); accept sample → p_hi.
  - Phase LO: code=max(centre−1, 0); accept sample → p_lo.
  - Then, comparing in PWR_WIDTH+1 bits: if p_hi < LOSS_THRESH and p_lo < LOSS_THRESH → FAULT. Else if p_hi > p_lo+DEADBAND, centre←centre+1 (saturating). Else if p_lo > p_hi+DEADBAND, centre←centre−1 (saturating). Otherwise centre holds.
  - Return to phase HI.
- FAULT: code=0. start&enable → SWEEP (same init as from IDLE).
- enable=0: next state IDLE and code=0 from any state, and all tracking registers cleared. This overrides start and any sample accepted in the same cycle.
- rst overrides enable and everything else.

## Timing
- All outputs are registered. A state change and the resulting code change appear on the same edge.
- start sampled at edge N → state=SWEEP, code=0 after edge N.
- Minimum dwell per code: SETTLE_CYCLES+1 cycles (the sample is taken on the last cycle). A full sweep takes ≥ 2^BW·(SETTLE_CYCLES+1) cycles.
- done is high for exactly the cycle after the final sweep sample, coincident with locked first going high and code=min(best_code+1, max) (phase HI).
- The centre update and the code change for the next phase HI occur on the edge that accepts p_lo.
- heater reflects the new code from the cycle after code changes. The accumulator is not cleared on code change, only on rst.

## Test plan
- PDM duty: BIT_WIDTH=8, drive to TRACK with centre 63 → in phase HI (code 64), exactly 64 heater highs per 256-cycle window; in IDLE heater=0 for all cycles.
- Sweep peak: SETTLE_CYCLES=4, pwr_valid always 1, pwr = 1000−4·|code−100| → done pulse after 256·5 sample cycles, best_code=100, state=2, locked=1.
- Tie and settle gating: flat pwr=500 → best_code=0. Also inject pwr=4000 at code 7 only while counter<SETTLE_CYCLES → ignored, best_code stays 0.
- Tracking: after lock at 100, move the peak to 103 → centre steps +1 per probe cycle, reaches 103 after 3 cycles, then holds with symmetric probes (difference ≤ DEADBAND). Peak at 0 → centre saturates at 0 with no underflow.
- Loss: in TRACK, pwr=10 (< LOSS_THRESH) for both probes → state=3, lost_lock=1, code=0, heater=0. A start pulse then restarts SWEEP with code=0.
- Abort: enable=0 mid-sweep at code 50 → next cycle state=0, code=0. rst asserted mid-TRACK → all outputs 0 next cycle, and start is ignored while rst is held.

Source files
------------

// File: rtl/ring_heater_lock_ctrl.sv
// Thermal lock controller for one ring resonator: PDM heater drive, a full-code
// sweep to find the drop-port peak, then +/-1 dither tracking of the resonance.
module ring_heater_lock_ctrl #(
   parameter int unsigned BIT_WIDTH     = 8,
   parameter int unsigned PWR_WIDTH     = 12,
   parameter int unsigned SETTLE_CYCLES = 1000,
   parameter int unsigned DEADBAND      = 4,
   parameter int unsigned LOSS_THRESH   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   input  logic                 start_i,
   input  logic                 pwr_valid_i,
   input  logic [PWR_WIDTH-1:0] pwr_data_i,
   output logic                 heater_o,
   output logic [BIT_WIDTH-1:0] code_o,
   output logic [1:0]           state_o,
   output logic                 locked_o,
   output logic                 done_o,
   output logic                 lost_lock_o
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned PX_W  = PWR_WIDTH + 1;
   localparam logic [BIT_WIDTH-1:0] CODE_MAX   = '1;
   localparam logic [CNT_W-1:0]     SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
   localparam logic [PX_W-1:0]      DB_X       = PX_W'(DEADBAND);
   localparam logic [PX_W-1:0]      LOSS_X     = PX_W'(LOSS_THRESH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      TRACK = 2'd2,
      FAULT = 2'd3
   } state_e;

   state_e               state_q;
   logic [BIT_WIDTH-1:0] code_q;
   logic [BIT_WIDTH-1:0] acc_q;
   logic                 heater_q;
   logic [CNT_W-1:0]     settle_q;
   logic [PWR_WIDTH-1:0] best_pwr_q;
   logic [BIT_WIDTH-1:0] best_code_q;
   logic [BIT_WIDTH-1:0] centre_q;
   logic                 phase_lo_q;
   logic [PWR_WIDTH-1:0] p_hi_q;
   logic                 locked_q;
   logic                 done_q;
   logic                 lost_lock_q;

   logic                 accept_d;
   logic [CNT_W-1:0]     settle_inc_d;
   logic [BIT_WIDTH-1:0] best_code_d;
   logic                 loss_d;
   logic [BIT_WIDTH-1:0] centre_d;
   logic [PX_W-1:0]      p_hi_x;
   logic [PX_W-1:0]      p_lo_x;

   function automatic logic [BIT_WIDTH-1:0] sat_inc(input logic [BIT_WIDTH-1:0] x);
      return (x == CODE_MAX) ? CODE_MAX : x + BIT_WIDTH'(1);
   endfunction

   function automatic logic [BIT_WIDTH-1:0] sat_dec(input logic [BIT_WIDTH-1:0] x);
      return (x == '0) ? '0 : x - BIT_WIDTH'(1);
   endfunction

   // Counter restarts only when the applied code actually moves.
   function automatic logic [CNT_W-1:0] settle_for(input logic [BIT_WIDTH-1:0] nc);
      return (nc != code_q) ? '0 : settle_inc_d;
   endfunction

   always_comb begin
      settle_inc_d = (settle_q == SETTLE_MAX) ? settle_q : settle_q + CNT_W'(1);
      accept_d     = pwr_valid_i && (settle_q == SETTLE_MAX);
      best_code_d  = (pwr_data_i > best_pwr_q) ? code_q : best_code_q;
      p_hi_x       = {1'b0, p_hi_q};
      p_lo_x       = {1'b0, pwr_data_i};
      loss_d       = (p_hi_x < LOSS_X) && (p_lo_x < LOSS_X);
      centre_d     = centre_q;
      if (p_hi_x > p_lo_x + DB_X) begin
         centre_d = sat_inc(centre_q);
      end else if (p_lo_x > p_hi_x + DB_X) begin
         centre_d = sat_dec(centre_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         code_q      <= '0;
         acc_q       <= '0;
         heater_q    <= 1'b0;
         settle_q    <= '0;
         best_pwr_q  <= '0;
         best_code_q <= '0;
         centre_q    <= '0;
         phase_lo_q  <= 1'b0;
         p_hi_q      <= '0;
         locked_q    <= 1'b0;
         done_q      <= 1'b0;
         lost_lock_q <= 1'b0;
      end else begin
         {heater_q, acc_q} <= {1'b0, acc_q} + {1'b0, code_q};
         settle_q <= settle_inc_d;
         done_q   <= 1'b0;
         if (!enable_i) begin
            state_q     <= IDLE;
            code_q      <= '0;
            settle_q    <= settle_for('0);
            best_pwr_q  <= '0;
            best_code_q <= '0;
            centre_q    <= '0;
            phase_lo_q  <= 1'b0;
            p_hi_q      <= '0;
            locked_q    <= 1'b0;
            lost_lock_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE, FAULT: begin
                  if (start_i) begin
                     state_q     <= SWEEP;
                     code_q      <= '0;
                     settle_q    <= '0;
                     best_pwr_q  <= '0;
                     best_code_q <= '0;
                     lost_lock_q <= 1'b0;
                  end
               end
               SWEEP: begin
                  if (accept_d) begin
                     if (pwr_data_i > best_pwr_q) begin
                        best_pwr_q  <= pwr_data_i;
                        best_code_q <= code_q;
                     end
                     if (code_q == CODE_MAX) begin
                        state_q    <= TRACK;
                        locked_q   <= 1'b1;
                        done_q     <= 1'b1;
                        centre_q   <= best_code_d;
                        phase_lo_q <= 1'b0;
                        code_q     <= sat_inc(best_code_d);
                        settle_q   <= settle_for(sat_inc(best_code_d));
                     end else begin
                        code_q   <= code_q + BIT_WIDTH'(1);
                        settle_q <= '0;
                     end
                  end
               end
               TRACK: begin
                  if (accept_d) begin
                     if (!phase_lo_q) begin
                        p_hi_q     <= pwr_data_i;
                        phase_lo_q <= 1'b1;
                        code_q     <= sat_dec(centre_q);
                        settle_q   <= settle_for(sat_dec(centre_q));
                     end else if (loss_d) begin
                        state_q     <= FAULT;
                        locked_q    <= 1'b0;
                        lost_lock_q <= 1'b1;
                        phase_lo_q  <= 1'b0;
                        code_q      <= '0;
                        settle_q    <= settle_for('0);
                     end else begin
                        centre_q   <= centre_d;
                        phase_lo_q <= 1'b0;
                        code_q     <= sat_inc(centre_d);
                        settle_q   <= settle_for(sat_inc(centre_d));
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign heater_o    = heater_q;
   assign code_o      = code_q;
   assign state_o     = state_q;
   assign locked_o    = locked_q;
   assign done_o      = done_q;
   assign lost_lock_o = lost_lock_q;

endmodule

// File: tb/tb_ring_heater_lock_ctrl.sv
// Directed bench for ring_heater_lock_ctrl: a table of sweep scenarios plus
// hand-written tracking, saturation, loss, abort and reset sequences.
module tb_ring_heater_lock_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        start;
   logic        pwr_valid;
   logic [11:0] pwr_data;
   logic        heater;
   logic [7:0]  code;
   logic [1:0]  state;
   logic        locked;
   logic        done;
   logic        lost_lock;

   ring_heater_lock_ctrl #(
      .BIT_WIDTH(8), .PWR_WIDTH(12), .SETTLE_CYCLES(4), .DEADBAND(4), .LOSS_THRESH(16)
   ) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .start_i(start),
      .pwr_valid_i(pwr_valid), .pwr_data_i(pwr_data),
      .heater_o(heater), .code_o(code), .state_o(state),
      .locked_o(locked), .done_o(done), .lost_lock_o(lost_lock)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Optical plant: 0 = triangular peak, 1 = flat 500, 2 = dark (10)
   int mode   = 0;
   int peak   = 100;
   int slope  = 4;
   bit inject = 1'b0;
   int dwell  = 0;
   int prev_code = 0;

   function automatic int plant(input int c, input int d);
      int v;
      case (mode)
         0: begin
            v = 1000 - slope * ((c > peak) ? c - peak : peak - c);
            if (v < 0) v = 0;
         end
         1:       v = 500;
         default: v = 10;
      endcase
      if (inject && c == 7 && d < 4) v = 4000;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // One clock; outputs are sampled and the plant updated 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (int'(code) != prev_code) dwell = 0;
      else dwell++;
      prev_code = int'(code);
      pwr_data = 12'(plant(int'(code), dwell));
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; start = 1'b0; pwr_valid = 1'b1;
      mode = 0; peak = 100; slope = 4; inject = 1'b0;
      step(); step();
      rst = 1'b0; enable = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_to_done(output int cycles);
      cycles = -1;
      for (int k = 1; k <= 2000; k++) begin
         step();
         if (done) begin
            cycles = k;
            break;
         end
      end
   endtask

   typedef struct {
      string name;
      int    mode;
      int    peak;
      int    slope;
      bit    inject;
      int    exp_cycles;
      int    exp_code;
   } sweep_vec_t;

   sweep_vec_t vecs[5];

   initial begin
      int cyc;
      int highs;
      int exp_track[5];

      rst = 1'b1; enable = 1'b0; start = 1'b0; pwr_valid = 1'b1; pwr_data = '0;

      vecs[0] = '{"peak100",      0, 100, 4, 1'b0, 1280, 101};
      vecs[1] = '{"flat_tie",     1,   0, 4, 1'b0, 1280,   1};
      vecs[2] = '{"flat_inject7", 1,   0, 4, 1'b1, 1280,   1};
      vecs[3] = '{"peak255",      0, 255, 4, 1'b0, 1280, 255};
      vecs[4] = '{"peak63",       0,  63, 4, 1'b0, 1280,  64};

      // Reset values while rst is held, with start and enable asserted
      step();
      enable = 1'b1; start = 1'b1;
      step();
      check("rst_state", state, 0);
      check("rst_code", code, 0);
      check("rst_heater", heater, 0);
      check("rst_flags", {locked, done, lost_lock}, 0);
      start = 1'b0;

      // IDLE never drives the heater
      do_reset();
      highs = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         highs += int'(heater);
      end
      check("idle_heater_highs", highs, 0);
      check("idle_state", state, 0);

      // enable=0 beats start
      enable = 1'b0; start = 1'b1;
      step();
      check("disabled_start_state", state, 0);
      start = 1'b0; enable = 1'b1;

      // Sweep scenarios
      foreach (vecs[v]) begin
         do_reset();
         mode = vecs[v].mode; peak = vecs[v].peak;
         slope = vecs[v].slope; inject = vecs[v].inject;
         pulse_start();
         check({vecs[v].name, "_start_state"}, state, 1);
         run_to_done(cyc);
         check({vecs[v].name, "_cycles"}, cyc, vecs[v].exp_cycles);
         check({vecs[v].name, "_code"}, code, vecs[v].exp_code);
         check({vecs[v].name, "_state"}, state, 2);
         check({vecs[v].name, "_locked"}, locked, 1);
         step();
         check({vecs[v].name, "_done_pulse"}, done, 0);
      end

      // PDM duty at code 64 in phase HI
      do_reset();
      peak = 63;
      pulse_start();
      run_to_done(cyc);
      pwr_valid = 1'b0;
      step();
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         highs += int'(heater);
      end
      check("duty_highs", highs, 64);
      check("duty_code", code, 64);
      pwr_valid = 1'b1;

      // Tracking: peak moves 100 -> 103, centre steps once per probe cycle
      do_reset();
      pulse_start();
      run_to_done(cyc);
      peak = 103;
      exp_track = '{102, 103, 104, 104, 104};
      for (int p = 0; p < 5; p++) begin
         repeat (10) step();
         check($sformatf("track_code_p%0d", p), code, exp_track[p]);
      end
      check("track_state", state, 2);

      // Centre saturates at 0 on a steep peak at code 0
      do_reset();
      peak = 0; slope = 8;
      pulse_start();
      run_to_done(cyc);
      check("sat0_lock_code", code, 1);
      repeat (5) step();
      check("sat0_lo_code", code, 0);
      repeat (5) step();
      check("sat0_hi_code", code, 1);
      repeat (10) step();
      check("sat0_hi_code2", code, 1);
      check("sat0_state", state, 2);

      // Loss of signal in TRACK, then restart from FAULT
      do_reset();
      pulse_start();
      run_to_done(cyc);
      mode = 2;
      repeat (9) step();
      check("loss_pre_state", state, 2);
      step();
      check("loss_state", state, 3);
      check("loss_flags", {locked, lost_lock}, 1);
      check("loss_code", code, 0);
      step(); step();
      check("loss_heater", heater, 0);
      pulse_start();
      check("restart_state", state, 1);
      check("restart_code", code, 0);
      check("restart_lost_lock", lost_lock, 0);

      // Abort mid-sweep at code 50
      do_reset();
      pulse_start();
      cyc = -1;
      for (int k = 0; k < 400; k++) begin
         if (code == 8'd50) begin
            cyc = k;
            break;
         end
         step();
      end
      check("abort_reach50", (cyc >= 0) ? 1 : 0, 1);
      enable = 1'b0;
      step();
      check("abort_state", state, 0);
      check("abort_code", code, 0);
      enable = 1'b1;

      // Reset mid-TRACK with start held
      do_reset();
      pulse_start();
      run_to_done(cyc);
      repeat (3) step();
      rst = 1'b1; start = 1'b1;
      step();
      check("trk_rst_state", state, 0);
      check("trk_rst_code", code, 0);
      check("trk_rst_flags", {heater, locked, done, lost_lock}, 0);
      step();
      check("trk_rst_hold_state", state, 0);
      start = 1'b0; rst = 1'b0;
      step();
      check("trk_rst_release_state", state, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
